pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  input  1  when high, hold PC and suppress retire.
REQ-005 SHALL have port pc_sel  input  2  next-PC source: 00 SEQ, 01 BRANCH, 10 JAL, 11 JALR.
REQ-006 SHALL have port branch_taken  input  1  branch condition from ALU; used only when pc_sel=BRANCH.
REQ-007 SHALL have port imm  input  32  sign-extended immediate.
REQ-008 SHALL have port rs1  input  32  register-file operand for JALR.
REQ-009 SHALL have port pc  output  32  current PC; feeds instruction memory and ALU operand-A mux.
REQ-010 SHALL have port pc_plus4  output  32  pc+4, the link value for JAL/JALR.
REQ-011 SHALL have port fetch_valid  output  1  high when pc is a valid fetch address.
REQ-012 SHALL have port misalign  output  1  one-cycle pulse on a misaligned redirect target.

Function
REQ-013 SHALL implement a 2-state FSM: BOOT, then RUN.
REQ-014 SHALL enter BOOT on rst; in BOOT, pc=RESET_VECTOR, fetch_valid=0, misalign=0.
REQ-015 SHALL move BOOT->RUN unconditionally on the first clock after rst deasserts; pc stays RESET_VECTOR across that edge.
REQ-016 SHALL drive fetch_valid=1 in RUN regardless of stall.
REQ-017 SHALL compute pc_plus4 combinationally as pc+4, modulo 2^32.
REQ-018 SHALL compute target: SEQ pc+4; BRANCH pc+imm if branch_taken else pc+4; JAL pc+imm; JALR (rs1+imm) with bit0 cleared; all modulo 2^32.
REQ-019 SHALL load target into pc on each RUN cycle with stall=0 and no misalign condition (latency 1 cycle).
REQ-020 SHALL hold pc when stall=1; stall takes priority over pc_sel, and misalign SHALL NOT assert while stalled.
REQ-021 SHALL treat a redirect (BRANCH taken, JAL, JALR) whose target[1] is 1 as misaligned: pc holds, misalign=1 for exactly that cycle's following clock.
REQ-022 SHALL never flag SEQ or not-taken BRANCH as misaligned.
REQ-023 SHALL wrap pc from 32'hFFFF_FFFC to 32'h0000_0000 on SEQ without error.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set pc=RESET_VECTOR, state=BOOT, misalign=0, counter=0, overriding stall and any in-flight redirect.
REQ-025 SHALL sample all other inputs as don't-care while rst=1.

Configuration
REQ-026 SHALL honour macro PC_UNIT_INSTRET_EN: when defined, add output instret (64 bits) counting RUN cycles with stall=0 and no misalign, cleared by rst, wrapping at 2^64.
REQ-027 SHALL, without PC_UNIT_INSTRET_EN, omit the instret port and counter entirely; all other behaviour identical.

Structure
REQ-028 SHALL take pc_sel encodings (SEQ/BRANCH/JAL/JALR), FSM state encodings and the default reset vector from shared package riscv_pkg.
REQ-029 SHALL place target/misalign computation in combinational sub-module pc_unit_next; pc_unit holds only state.

Verification
REQ-030 SHALL cover reset: rst=1 two cycles then 0 -> pc=0, fetch_valid 0 then 1 on the next edge, pc=0 then 4 after next SEQ edge.
REQ-031 SHALL cover branch: pc=0x100, pc_sel=BRANCH, imm=0xFFFFFFF0, taken=1 -> pc=0xF0; same with taken=0 -> pc=0x104.
REQ-032 SHALL cover JALR: rs1=0x2001, imm=0x4, pc_sel=JALR -> pc=0x2004, pc_plus4 before the edge = old pc+4.
REQ-033 SHALL cover misalign: pc=0x40, JAL imm=0x6 -> pc stays 0x40, misalign=1 for one cycle; with stall=1 -> no pulse.
REQ-034 SHALL cover stall and wrap: stall=1 for 3 cycles -> pc constant (instret constant if enabled); pc=0xFFFFFFFC, SEQ -> pc=0.
REQ-035 SHALL cover mid-operation reset: rst=1 concurrent with JAL redirect -> pc=RESET_VECTOR, state BOOT, instret=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared PC-unit encodings: next-PC select codes, fetch FSM states and default reset vector.
package riscv_pkg;

   typedef enum logic [1:0] {
      PcSeq    = 2'b00,
      PcBranch = 2'b01,
      PcJal    = 2'b10,
      PcJalr   = 2'b11
   } pc_sel_e;

   typedef enum logic [0:0] {
      StBoot = 1'b0,
      StRun  = 1'b1
   } pc_state_e;

   localparam logic [31:0] DefaultResetVector = 32'h0000_0000;

endpackage

// File: rtl/pc_unit_next.sv
// Combinational next-PC target selection and misaligned-redirect detection.
module pc_unit_next
   import riscv_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pc_sel,
   input  logic        branch_taken,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   output logic [31:0] target,
   output logic [31:0] pc_plus4,
   output logic        misaligned
);

   logic [31:0] pc_rel;
   logic [31:0] reg_rel;
   logic        redirect;
   pc_sel_e     sel;

   assign sel      = pc_sel_e'(pc_sel);
   assign pc_plus4 = pc + 32'd4;
   assign pc_rel   = pc + imm;
   assign reg_rel  = rs1 + imm;

   always_comb begin
      target   = pc_plus4;
      redirect = 1'b0;
      unique case (sel)
         PcSeq: begin
            target   = pc_plus4;
            redirect = 1'b0;
         end
         PcBranch: begin
            target   = branch_taken ? pc_rel : pc_plus4;
            redirect = branch_taken;
         end
         PcJal: begin
            target   = pc_rel;
            redirect = 1'b1;
         end
         PcJalr: begin
            target   = {reg_rel[31:1], 1'b0};
            redirect = 1'b1;
         end
      endcase
   end

   // Only bit 1 matters: bit 0 is either cleared (JALR) or not checked.
   assign misaligned = redirect & target[1];

endmodule

// File: rtl/pc_unit.sv
// Program counter state: BOOT/RUN FSM, PC register and misalign pulse.
// Optional 64-bit retired-cycle counter when PC_UNIT_INSTRET_EN is defined.
module pc_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DefaultResetVector
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [1:0]  pc_sel,
   input  logic        branch_taken,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
`ifdef PC_UNIT_INSTRET_EN
   output logic [63:0] instret,
`endif
   output logic        misalign
);

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        misalign_q, misalign_d;
   logic [31:0] target;
   logic        misaligned;
   logic        advance;

   pc_unit_next u_next (
      .pc           (pc_q),
      .pc_sel       (pc_sel),
      .branch_taken (branch_taken),
      .imm          (imm),
      .rs1          (rs1),
      .target       (target),
      .pc_plus4     (pc_plus4),
      .misaligned   (misaligned)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = 1'b0;
      advance    = 1'b0;
      unique case (state_q)
         StBoot: begin
            state_d = StRun;
         end
         StRun: begin
            // Stall wins over everything, including the misalign pulse.
            advance    = ~stall & ~misaligned;
            misalign_d = ~stall & misaligned;
            if (advance) begin
               pc_d = target;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StBoot;
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

`ifdef PC_UNIT_INSTRET_EN
   logic [63:0] instret_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= 64'd0;
      end else if (advance) begin
         instret_q <= instret_q + 64'd1;
      end
   end

   assign instret = instret_q;
`endif

   assign pc          = pc_q;
   assign fetch_valid = (state_q == StRun);
   assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver pushes model expectations, monitor pops and compares.
module tb_pc_unit;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic [1:0]  pc_sel = 2'b00;
   logic        branch_taken = 1'b0;
   logic [31:0] imm = 32'd0;
   logic [31:0] rs1 = 32'd0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        misalign;
`ifdef PC_UNIT_INSTRET_EN
   logic [63:0] instret;
`endif

   pc_unit #(.RESET_VECTOR(RV)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .pc_sel       (pc_sel),
      .branch_taken (branch_taken),
      .imm          (imm),
      .rs1          (rs1),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .fetch_valid  (fetch_valid),
`ifdef PC_UNIT_INSTRET_EN
      .instret      (instret),
`endif
      .misalign     (misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        fv;
      logic        mis;
      logic [63:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state, in architectural terms.
   logic [31:0] m_pc  = RV;
   bit          m_run = 0;
   bit          m_mis = 0;
   longint unsigned m_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input int sel, input bit tk,
                             input logic [31:0] im, input logic [31:0] r1);
      logic [31:0] tgt;
      bit          jump;
      if (r) begin
         m_pc = RV; m_run = 0; m_mis = 0; m_cnt = 0;
      end else if (!m_run) begin
         m_run = 1; m_mis = 0;
      end else if (s) begin
         m_mis = 0;
      end else begin
         jump = (sel == 2) || (sel == 3) || (sel == 1 && tk);
         if (sel == 3)             tgt = (r1 + im) - ((r1 + im) % 2);
         else if (jump)            tgt = m_pc + im;
         else                      tgt = m_pc + 4;
         if (jump && ((tgt / 2) % 2 == 1)) begin
            m_mis = 1;
         end else begin
            m_pc = tgt; m_mis = 0; m_cnt++;
         end
      end
   endtask

   task automatic drive(input bit r, input bit s, input int sel, input bit tk,
                        input logic [31:0] im, input logic [31:0] r1);
      exp_t e;
      @(negedge clk);
      rst = r; stall = s; pc_sel = 2'(sel); branch_taken = tk; imm = im; rs1 = r1;
      model_step(r, s, sel, tk, im, r1);
      e.pc = m_pc; e.fv = m_run; e.mis = m_mis; e.cnt = m_cnt;
      q.push_back(e);
   endtask

   // Monitor: every edge that has an outstanding expectation is checked.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pc", {32'd0, pc}, {32'd0, e.pc});
            check("pc_plus4", {32'd0, pc_plus4}, {32'd0, e.pc + 32'd4});
            check("fetch_valid", {63'd0, fetch_valid}, {63'd0, e.fv});
            check("misalign", {63'd0, misalign}, {63'd0, e.mis});
`ifdef PC_UNIT_INSTRET_EN
            check("instret", instret, e.cnt);
`endif
         end
      end
   end

   initial begin
      int  sel;
      bit  r, s, tk;
      logic [31:0] im, r1;

      // Reset two cycles, then BOOT->RUN with pc held, then sequential step.
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      // Reach 0x100, branch back taken / not taken.
      drive(0, 0, 2, 0, 32'h0000_00FC, 0);
      drive(0, 0, 1, 1, 32'hFFFF_FFF0, 0);
      drive(0, 0, 2, 0, 32'h0000_0010, 0);
      drive(0, 0, 1, 0, 32'hFFFF_FFF0, 0);
      // JALR with bit 0 cleared.
      drive(0, 0, 3, 0, 32'h0000_0004, 32'h0000_2001);
      // Misaligned JAL from 0x40, then same while stalled.
      drive(0, 0, 3, 0, 32'h0000_0000, 32'h0000_0040);
      drive(0, 0, 2, 0, 32'h0000_0006, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 1, 2, 0, 32'h0000_0006, 0);
      drive(0, 0, 0, 0, 0, 0);
      // Stall three cycles with a redirect pending, then wrap on SEQ.
      for (int i = 0; i < 3; i++) drive(0, 1, 2, 0, 32'h0000_0100, 0);
      drive(0, 0, 3, 0, 32'h0000_0000, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      // Reset concurrent with a JAL redirect.
      drive(0, 0, 2, 0, 32'h0000_0020, 0);
      drive(1, 1, 2, 0, 32'h0000_0020, 0);
      drive(0, 0, 2, 0, 32'h0000_0020, 0);
      drive(0, 0, 2, 0, 32'h0000_0020, 0);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 39) == 0);
         s   = ($urandom_range(0, 3) == 0);
         sel = int'($urandom_range(0, 3));
         tk  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) im = $urandom;
         else                            im = 32'($urandom_range(0, 64)) - 32'd32;
         r1  = $urandom;
         drive(r, s, sel, tk, im, r1);
      end

      @(negedge clk);
      @(negedge clk);
      check("queue_drain", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
